seq_detect_sched: RTL
=====================

Name: seq_detect_sched

Overview:
- Shares one programmable serial pattern-match engine among NUM_CH independent bit streams.
- A round-robin scheduler grants at most one lane per cycle and shifts that lane's bit into its private history register.
- One shared comparator checks the history against the configured pattern and reports matches tagged with the lane ID.
- Sits between the serial input lanes and the event/interrupt logic. Generalises the fixed "11" Moore detector to N lanes with a configurable pattern.

Parameters:
NUM_CH, 4, number of input lanes (2..16)
PAT_W, 8, maximum pattern length in bits
CH_W, $clog2(NUM_CH), lane-ID width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  reset
enable  in  1  run request; low forces IDLE
cfg_load  in  1  latch cfg_pattern/cfg_len (honoured in IDLE only)
cfg_pattern  in  PAT_W  pattern; bit cfg_len-1 = oldest bit, bit 0 = newest
cfg_len  in  4  pattern length
in_valid  in  NUM_CH  per-lane bit valid
in_bit  in  NUM_CH  per-lane data bit
in_ready  out  NUM_CH  one-hot grant (combinational)
match_valid  out  1  match pulse, registered
match_ch  out  CH_W  lane that matched
busy  out  1  high in ARM or RUN
cnt_sel  in  CH_W  counter read select
cnt_clr  in  1  clear all match counters
cnt_data  out  8  match count of lane cnt_sel

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
- Reset state: state=IDLE; in_ready=0; match_valid=0; match_ch=0; busy=0.
- Reset also sets: all histories 0, fill counters 0, RR pointer 0, pattern=8'b0000_0011, len=2 (default "11" detector).
- Config clamp: cfg_len 0 is stored as 1; values >PAT_W are stored as PAT_W. cfg_load is ignored outside IDLE.
- State IDLE: in_ready=0. Next state is ARM when enable=1.
- State ARM: lasts 1 cycle. Clears all histories and fill counters. Next state is RUN, or IDLE if enable=0.
- State RUN: arbitration active. Next state is IDLE when enable=0; a transfer in that same cycle still completes.
- Arbitration:
  - Grant the first lane with in_valid=1, searching from the RR pointer upward with wrap.
  - in_ready is one-hot on that lane, or all 0 if no lane is valid.
  - A transfer occurs when in_valid & in_ready.
  - After a transfer, pointer = granted+1 mod NUM_CH. With no transfer, the pointer holds.
- Transfer to lane g:
  - hist[g] <= {hist[g][PAT_W-2:0], in_bit[g]}.
  - fill[g] <= min(fill[g]+1, PAT_W).
- Match check:
  - Computed on the new history value.
  - Match when fill_new >= len AND the low len bits of hist_new equal the low len bits of pattern.
  - On a match, match_valid=1 and match_ch=g in the next cycle (latency 1); match_valid is 0 otherwise.
  - Overlapping matches are allowed; the history is not cleared on a match.
- Reset asserted mid-RUN: immediate return to reset values; any pending match pulse is dropped.
- enable low: histories hold and in_ready=0. Re-enabling passes through ARM, which clears them.

Optional Feature:
- Macro: MATCH_CNT_EN.
- Defined:
  - Per-lane 8-bit match counters increment on each match and saturate at 255.
  - cnt_clr=1 zeroes all counters; clear wins over a same-cycle increment.
  - cnt_data = counter[cnt_sel] (combinational). Counters reset to 0.
- Undefined: no counters; cnt_data tied to 0; cnt_sel and cnt_clr ignored.

Test Plan:
- Default config, enable=1, lane 0 only, bits 0,1,1,1 -> match_valid pulses 1 cycle after the 3rd and 4th bits, match_ch=0; no other pulses.
- cfg_load in IDLE with pattern=8'b0000_1101, len=4; lane 2 bits 1,1,0,1,1,0,1 -> matches after the 4th and 7th bits (overlap), match_ch=2.
- All 4 lanes in_valid=1 continuously -> in_ready cycles through lanes 0,1,2,3,0,…, one-hot; each lane receives exactly every 4th cycle.
- Lanes 1 and 3 interleaved with default pattern, each sending 1,1 -> two matches with match_ch=1 and match_ch=3, with no cross-lane contamination.
- cfg_load while in RUN (len=3) -> ignored, len stays 2; enable toggles 0→1 -> ARM for 1 cycle (busy=1, in_ready=0), lane 0 sends one bit 1 -> no match (fill=1 < len).
- MATCH_CNT_EN defined, 300 matches on lane 1 -> cnt_sel=1 gives cnt_data=255; cnt_clr pulse -> 0; reset asserted mid-stream -> match_valid=0 and busy=0 immediately.

Source files
------------

// File: rtl/seq_detect_sched.sv
// ---------------------------------------------------------------------------
// seq_detect_sched
//   Time-shares one programmable serial pattern matcher across NUM_CH bit
//   lanes. A round-robin arbiter grants at most one valid lane per cycle. The
//   granted bit is shifted into that lane's private history register, and the
//   shared comparator checks the new history against the configured pattern.
//   A match is reported one cycle later, tagged with the lane ID.
//   The reset configuration (pattern 2'b11, length 2) is the classic "11"
//   detector.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   enable            run request; low returns the engine to IDLE
//   cfg_load          latch cfg_pattern / cfg_len (honoured in IDLE only)
//   cfg_pattern       pattern, bit cfg_len-1 oldest, bit 0 newest
//   cfg_len           pattern length (0 -> 1, >PAT_W -> PAT_W)
//   in_valid, in_bit  per-lane valid and data bit
//   in_ready          one-hot grant (combinational)
//   match_valid       registered match pulse
//   match_ch          lane that produced the match
//   busy              high while in ARM or RUN
//   cnt_sel, cnt_clr  match-counter read select / clear-all
//   cnt_data          match count of lane cnt_sel
//
// Build option
//   MATCH_CNT_EN      when defined, adds per-lane saturating 8-bit match
//                     counters. When undefined, cnt_data is tied to 0.
// ---------------------------------------------------------------------------
module seq_detect_sched #(
  parameter  int NUM_CH = 4,
  parameter  int PAT_W  = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [NUM_CH-1:0] in_bit,
  output logic [NUM_CH-1:0] in_ready,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  output logic              busy,
  input  logic [CH_W-1:0]   cnt_sel,
  input  logic              cnt_clr,
  output logic [7:0]        cnt_data
);

  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [FILL_W-1:0]  len_q, len_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [PAT_W-1:0]   hist_q [NUM_CH];
  logic [PAT_W-1:0]   hist_d [NUM_CH];
  logic [FILL_W-1:0]  fill_q [NUM_CH];
  logic [FILL_W-1:0]  fill_d [NUM_CH];
  logic               match_valid_q, match_valid_d;
  logic [CH_W-1:0]    match_ch_q, match_ch_d;
  logic               busy_q, busy_d;

  // Round-robin arbitration: first valid lane at or above the pointer, with wrap.
  logic               grant_any;
  logic [CH_W-1:0]    grant_idx;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    in_ready  = '0;
    if (state_q == RUN) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        idx = (32'(rr_q) + i) % NUM_CH;
        if (!grant_any && in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = CH_W'(idx);
        end
      end
      if (grant_any) begin
        in_ready[grant_idx] = 1'b1;
      end
    end
  end

  // Shared comparator, evaluated on the post-shift history of the granted lane.
  logic [PAT_W-1:0]   hist_new;
  logic [FILL_W-1:0]  fill_new;
  logic [PAT_W-1:0]   len_mask;
  logic               match_hit;

  always_comb begin
    hist_new = {hist_q[grant_idx][PAT_W-2:0], in_bit[grant_idx]};
    fill_new = (fill_q[grant_idx] == FILL_MAX) ? FILL_MAX
                                               : fill_q[grant_idx] + FILL_W'(1);
    len_mask = '0;
    for (int unsigned b = 0; b < PAT_W; b++) begin
      len_mask[b] = (b < 32'(len_q));
    end
    match_hit = (fill_new >= len_q) && (((hist_new ^ pat_q) & len_mask) == '0);
  end

  // Length clamp for cfg_load.
  logic [31:0]        cfg_len_u;
  logic [FILL_W-1:0]  cfg_len_clamped;

  assign cfg_len_u = 32'(cfg_len);

  always_comb begin
    if (cfg_len_u == 32'd0) begin
      cfg_len_clamped = FILL_W'(1);
    end else if (cfg_len_u > PAT_W) begin
      cfg_len_clamped = FILL_MAX;
    end else begin
      cfg_len_clamped = FILL_W'(cfg_len_u);
    end
  end

  // Next-state logic for the controller and all lane state.
  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    len_d         = len_q;
    rr_d          = rr_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;

    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          pat_d = cfg_pattern;
          len_d = cfg_len_clamped;
        end
        if (enable) begin
          state_d = ARM;
        end
      end
      ARM: begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
          hist_d[ch] = '0;
          fill_d[ch] = '0;
        end
        state_d = enable ? RUN : IDLE;
      end
      RUN: begin
        // A grant issued in the cycle enable drops still completes.
        if (grant_any) begin
          hist_d[grant_idx] = hist_new;
          fill_d[grant_idx] = fill_new;
          rr_d              = CH_W'((32'(grant_idx) + 32'd1) % NUM_CH);
          if (match_hit) begin
            match_valid_d = 1'b1;
            match_ch_d    = grant_idx;
          end
        end
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pat_q         <= PAT_W'(3);
      len_q         <= FILL_W'(2);
      rr_q          <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      busy_q        <= 1'b0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        hist_q[ch] <= '0;
        fill_q[ch] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      len_q         <= len_d;
      rr_q          <= rr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      busy_q        <= busy_d;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        hist_q[ch] <= hist_d[ch];
        fill_q[ch] <= fill_d[ch];
      end
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign busy        = busy_q;

`ifdef MATCH_CNT_EN
  logic [7:0] cnt_q [NUM_CH];
  logic [7:0] cnt_d [NUM_CH];

  // Clear has priority over an increment in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        cnt_d[ch] = '0;
      end
    end else if (match_valid_d && (cnt_q[grant_idx] != 8'hFF)) begin
      cnt_d[grant_idx] = cnt_q[grant_idx] + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign cnt_data = (32'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : '0;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, cnt_clr};
  assign cnt_data   = '0;
`endif

endmodule
